// File: rtl/prbs_frame_tx.sv
// Framed PRBS-31-style word source on an AXI-Stream master. The LFSR is reseeded at every frame.
// Each frame carries sof/eof sidebands, and a single-word error-injection hook feeds the receiver's checker.
module prbs_frame_tx #(
  parameter int C_LEN_W = 16,
  parameter int C_GAP_W = 8
) (
  input  logic               i_aclk,
  input  logic               i_areset,
  input  logic               i_enable,
  input  logic [31:0]        i_prbs_seed,
  input  logic [C_LEN_W-1:0] i_frame_len,
  input  logic [C_GAP_W-1:0] i_gap_len,
  input  logic               i_inject_err,
  input  logic               m_axis_tready,
  output logic               m_axis_tvalid,
  output logic [31:0]        m_axis_tdata,
  output logic               m_axis_sof,
  output logic               m_axis_eof,
  output logic [31:0]        o_frame_cnt,
  output logic               o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_GAP
  } state_t;

  state_t             state;
  logic [31:0]        lfsr;
  logic [C_LEN_W-1:0] len;
  logic [C_LEN_W-1:0] word_cnt;
  logic [C_GAP_W-1:0] gap;
  logic [C_GAP_W-1:0] gap_cnt;
  logic               err_pending;
  logic               err_beat;
  logic               tvalid;
  logic [31:0]        frame_cnt;

  logic handshake;
  logic last_word;
  logic beat_start;

  // Fibonacci LFSR, taps 32,22,2,1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  assign handshake  = tvalid & m_axis_tready;
  assign last_word  = (word_cnt == len - C_LEN_W'(1));
  // A beat starts either on LOAD (word 0) or on the acceptance of a non-last word.
  assign beat_start = (state == S_LOAD) | (handshake & ~last_word);

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      state       <= S_IDLE;
      lfsr        <= 32'h1;
      len         <= C_LEN_W'(1);
      word_cnt    <= '0;
      gap         <= '0;
      gap_cnt     <= '0;
      err_pending <= 1'b0;
      err_beat    <= 1'b0;
      tvalid      <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every term below reads the pre-edge value;
      // that is what makes a same-cycle inject pulse miss the beat that starts on this edge.
      err_pending <= (err_pending & ~beat_start) | (i_inject_err & ~err_pending);

      case (state)
        S_IDLE: begin
          if (i_enable) state <= S_LOAD;
        end

        S_LOAD: begin
          lfsr     <= (i_prbs_seed == 32'h0) ? 32'h1 : i_prbs_seed;
          len      <= (i_frame_len == '0) ? C_LEN_W'(1) : i_frame_len;
          gap      <= i_gap_len;
          word_cnt <= '0;
          err_beat <= err_pending;
          tvalid   <= 1'b1;
          state    <= S_SEND;
        end

        S_SEND: begin
          if (handshake) begin
            if (!last_word) begin
              lfsr     <= lfsr_next(lfsr);
              word_cnt <= word_cnt + C_LEN_W'(1);
              err_beat <= err_pending;
            end else begin
              frame_cnt <= frame_cnt + 32'd1;
              err_beat  <= 1'b0;
              tvalid    <= 1'b0;
              if (gap != '0) begin
                gap_cnt <= gap;
                state   <= S_GAP;
              end else if (i_enable) begin
                state <= S_LOAD;
              end else begin
                state <= S_IDLE;
              end
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == C_GAP_W'(1)) begin
            gap_cnt <= '0;
            state   <= i_enable ? S_LOAD : S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - C_GAP_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are gated by the registered valid so everything reads zero outside SEND.
  assign m_axis_tvalid = tvalid;
  assign m_axis_tdata  = tvalid ? (lfsr ^ {31'b0, err_beat}) : 32'h0;
  assign m_axis_sof    = tvalid & (word_cnt == '0);
  assign m_axis_eof    = tvalid & last_word;
  assign o_frame_cnt   = frame_cnt;
  assign o_busy        = (state != S_IDLE);

endmodule

// File: tb/tb_prbs_frame_tx.sv
// Scoreboard bench for prbs_frame_tx: stimulus pushes hand-computed beats, a negedge monitor pops and compares.
module tb_prbs_frame_tx;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] seed;
  logic [15:0] frame_len;
  logic [7:0]  gap_len;
  logic        inject_err;
  logic        tready;
  logic        tvalid;
  logic [31:0] tdata;
  logic        sof;
  logic        eof;
  logic [31:0] frame_cnt;
  logic        busy;

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic        eof;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  prbs_frame_tx #(.C_LEN_W(16), .C_GAP_W(8)) dut (
    .i_aclk        (clk),
    .i_areset      (rst),
    .i_enable      (enable),
    .i_prbs_seed   (seed),
    .i_frame_len   (frame_len),
    .i_gap_len     (gap_len),
    .i_inject_err  (inject_err),
    .m_axis_tready (tready),
    .m_axis_tvalid (tvalid),
    .m_axis_tdata  (tdata),
    .m_axis_sof    (sof),
    .m_axis_eof    (eof),
    .o_frame_cnt   (frame_cnt),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic s, input logic e);
    beat_t b;
    b.data = d;
    b.sof  = s;
    b.eof  = e;
    exp_q.push_back(b);
  endtask

  task automatic push_frame4(input logic [31:0] w2);
    push(32'h1, 1'b1, 1'b0);
    push(32'h3, 1'b0, 1'b0);
    push(w2,    1'b0, 1'b0);
    push(32'hD, 1'b0, 1'b1);
  endtask

  // Inputs change 2 time units after the active edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    enable     = 1'b0;
    inject_err = 1'b0;
    tready     = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (frame_cnt != 32'(n) && k < 200) begin
      tick();
      k++;
    end
    check("wait_frame_cnt", {2'b0, frame_cnt}, 34'(n));
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 200) begin
      tick();
      k++;
    end
    check("wait_idle_busy", {33'b0, busy}, 34'd0);
  endtask

  task automatic check_drained(input string name);
    check(name, 34'(exp_q.size()), 34'd0);
  endtask

  // Monitor: every presented beat is compared against the queue head; accepted beats pop it.
  always @(negedge clk) begin
    if (!rst && tvalid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {tdata, sof, eof}, 34'h0);
      end else begin
        check(tready ? "beat" : "stalled_beat", {tdata, sof, eof}, exp_q[0]);
        if (tready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [3:0] pat;
    int idle_cycles;

    seed      = 32'h1;
    frame_len = 16'd4;
    gap_len   = 8'd0;
    do_reset();

    // Reset state.
    check("reset_tvalid", {33'b0, tvalid}, 34'd0);
    check("reset_tdata", {2'b0, tdata}, 34'd0);
    check("reset_sof_eof", {32'b0, sof, eof}, 34'd0);
    check("reset_frame_cnt", {2'b0, frame_cnt}, 34'd0);
    check("reset_busy", {33'b0, busy}, 34'd0);

    // Basic frame, two back-to-back frames, latency of two edges.
    push_frame4(32'h6);
    push_frame4(32'h6);
    enable = 1'b1;
    tick();
    check("latency_load_tvalid", {33'b0, tvalid}, 34'd0);
    check("latency_load_busy", {33'b0, busy}, 34'd1);
    tick();
    check("latency_send_tvalid", {33'b0, tvalid}, 34'd1);
    wait_frames(1);
    check("back_to_back_load_tvalid", {33'b0, tvalid}, 34'd0);
    enable = 1'b0;
    wait_idle();
    check("t1_frame_cnt", {2'b0, frame_cnt}, 34'd2);
    check_drained("t1_drained");

    // Seed 0 and length 0 both degrade to 1: single-word frames.
    do_reset();
    seed      = 32'h0;
    frame_len = 16'd0;
    repeat (3) push(32'h1, 1'b1, 1'b1);
    enable = 1'b1;
    wait_frames(2);
    enable = 1'b0;
    wait_idle();
    check("t2_frame_cnt", {2'b0, frame_cnt}, 34'd3);
    check_drained("t2_drained");

    // Backpressure 1,0,0,1: words held, none skipped or duplicated.
    do_reset();
    seed      = 32'h1;
    frame_len = 16'd4;
    pat       = 4'b1001;
    push_frame4(32'h6);
    push_frame4(32'h6);
    enable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tready = pat[i % 4];
      tick();
      if (frame_cnt == 32'd1) enable = 1'b0;
      if (!busy && !enable) break;
    end
    tready = 1'b1;
    check("t3_frame_cnt", {2'b0, frame_cnt}, 34'd2);
    check("t3_busy", {33'b0, busy}, 34'd0);
    check_drained("t3_drained");

    // Gap 3: three GAP cycles plus one LOAD between eof handshake and next sof.
    do_reset();
    frame_len = 16'd2;
    gap_len   = 8'd3;
    repeat (2) begin
      push(32'h1, 1'b1, 1'b0);
      push(32'h3, 1'b0, 1'b1);
    end
    enable = 1'b1;
    wait_frames(1);
    idle_cycles = 0;
    for (int i = 0; i < 50 && !tvalid; i++) begin
      idle_cycles++;
      tick();
    end
    check("t4_idle_cycles", 34'(idle_cycles), 34'd4);
    check("t4_sof_after_gap", {33'b0, sof}, 34'd1);
    enable = 1'b0;
    wait_idle();
    check("t4_frame_cnt", {2'b0, frame_cnt}, 34'd2);
    check_drained("t4_drained");

    // Enable dropped after word 1: frame completes in full, then IDLE.
    do_reset();
    frame_len = 16'd4;
    gap_len   = 8'd0;
    push_frame4(32'h6);
    enable = 1'b1;
    repeat (4) tick();
    enable = 1'b0;
    wait_idle();
    check("t5_frame_cnt", {2'b0, frame_cnt}, 34'd1);
    check("t5_tvalid", {33'b0, tvalid}, 34'd0);
    check_drained("t5_drained");

    // Inject during word 1 stall: only word 2 corrupted. Then reset mid-frame.
    do_reset();
    push_frame4(32'h7);
    enable = 1'b1;
    tick();
    tick();
    tick();
    tready     = 1'b0;
    inject_err = 1'b1;
    tick();
    inject_err = 1'b0;
    tick();
    tready = 1'b1;
    wait_frames(1);
    check_drained("t6_drained");
    push(32'h1, 1'b1, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("t6_rst_tvalid", {33'b0, tvalid}, 34'd0);
    check("t6_rst_tdata", {2'b0, tdata}, 34'd0);
    check("t6_rst_sof_eof", {32'b0, sof, eof}, 34'd0);
    check("t6_rst_frame_cnt", {2'b0, frame_cnt}, 34'd0);
    check("t6_rst_busy", {33'b0, busy}, 34'd0);
    check_drained("t6_pre_reset_drained");
    tick();
    rst = 1'b0;
    push_frame4(32'h6);
    tick();
    tick();
    enable = 1'b0;
    wait_idle();
    check("t6_restart_frame_cnt", {2'b0, frame_cnt}, 34'd1);
    check_drained("t6_restart_drained");

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
